// File: rtl/vga_pkg.sv
// Shared VGA 640x480 timing constants, monitor state type and pixel weight helper.
package vga_pkg;

  localparam int H_ACTIVE     = 640;
  localparam int H_TOTAL      = 800;
  localparam int V_ACTIVE     = 480;
  localparam int V_TOTAL      = 525;
  localparam int FRAME_PIXELS = 307200;

  typedef enum logic [1:0] {
    HUNT    = 2'd0,
    MEASURE = 2'd1,
    LOCKED  = 2'd2
  } mon_state_t;

  // r+g+b of one pixel; 10 bits covers 3*255 without loss.
  function automatic logic [9:0] pixel_weight(input logic [7:0] r,
                                              input logic [7:0] g,
                                              input logic [7:0] b);
    return 10'(r) + 10'(g) + 10'(b);
  endfunction

endpackage

// File: rtl/vga_edge_detect.sv
// Registers one sync input and flags its falling edge (registered previous 1, current 0).
module vga_edge_detect (
  input  logic clk,
  input  logic rst,
  input  logic sig,
  output logic fall
);

  logic cur_reg;
  logic prev_reg;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cur_reg  <= 1'b0;
      prev_reg <= 1'b0;
    end else begin
      cur_reg  <= sig;
      prev_reg <= cur_reg;
    end
  end

  assign fall = prev_reg & ~cur_reg;

endmodule

// File: rtl/vga_monitor.sv
// VGA timing monitor: checks sync timing, tracks frame lock and republishes active
// pixels with coordinates and a per-frame colour checksum.
module vga_monitor
  import vga_pkg::*;
#(
  parameter int LINE_CYCLES   = vga_pkg::H_TOTAL,
  parameter int FRAME_LINES   = vga_pkg::V_TOTAL,
  parameter int ACTIVE_PIXELS = vga_pkg::FRAME_PIXELS
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        hsync,
  input  logic        vsync,
  input  logic        blank,
  input  logic [7:0]  vga_r,
  input  logic [7:0]  vga_g,
  input  logic [7:0]  vga_b,
  output logic        locked,
  output logic        pixel_valid,
  output logic [9:0]  pixelx,
  output logic [9:0]  pixely,
  output logic [7:0]  pix_r,
  output logic [7:0]  pix_g,
  output logic [7:0]  pix_b,
  output logic        frame_done,
  output logic [15:0] frame_sum,
  output logic        timing_err
);

  localparam logic [9:0]  HCNT_GOOD   = 10'(LINE_CYCLES - 1);
  localparam logic [9:0]  VCNT_GOOD   = 10'(FRAME_LINES);
  localparam logic [18:0] ACTIVE_GOOD = 19'(ACTIVE_PIXELS);
  localparam logic [9:0]  CNT10_MAX   = '1;
  localparam logic [18:0] ACTIVE_MAX  = '1;

  logic [1:0]  sync_in;
  logic [1:0]  sync_fall;
  logic        hfall;
  logic        vfall;

  logic        blank_reg;
  logic [7:0]  r_reg;
  logic [7:0]  g_reg;
  logic [7:0]  b_reg;

  logic [9:0]  hcnt_reg;
  logic [9:0]  vcnt_reg;
  logic [18:0] active_cnt_reg;
  logic [15:0] sum_reg;
  logic [9:0]  x_reg;
  logic [9:0]  y_reg;
  logic        line_active_reg;

  mon_state_t  state_reg;
  logic [9:0]  weight;
  logic        line_bad;
  logic        frame_bad;
  logic        check_err;
  logic        lock_next;

  assign sync_in = {vsync, hsync};

  for (genvar gi = 0; gi < 2; gi++) begin : g_sync
    vga_edge_detect u_edge (
      .clk  (clk),
      .rst  (rst),
      .sig  (sync_in[gi]),
      .fall (sync_fall[gi])
    );
  end

  assign hfall = sync_fall[0];
  assign vfall = sync_fall[1];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      blank_reg <= 1'b0;
      r_reg     <= 8'd0;
      g_reg     <= 8'd0;
      b_reg     <= 8'd0;
    end else begin
      blank_reg <= blank;
      r_reg     <= vga_r;
      g_reg     <= vga_g;
      b_reg     <= vga_b;
    end
  end

  assign weight = pixel_weight(r_reg, g_reg, b_reg);

  // Frame counters restart at a vsync fall; an hsync fall or pixel in that same
  // cycle already belongs to the new frame.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      hcnt_reg        <= 10'd0;
      vcnt_reg        <= 10'd0;
      active_cnt_reg  <= 19'd0;
      sum_reg         <= 16'd0;
      x_reg           <= 10'd0;
      y_reg           <= 10'd0;
      line_active_reg <= 1'b0;
    end else begin
      if (hfall) begin
        hcnt_reg <= 10'd0;
      end else if (hcnt_reg != CNT10_MAX) begin
        hcnt_reg <= hcnt_reg + 10'd1;
      end

      if (vfall) begin
        vcnt_reg <= {9'd0, hfall};
      end else if (hfall && vcnt_reg != CNT10_MAX) begin
        vcnt_reg <= vcnt_reg + 10'd1;
      end

      if (vfall) begin
        active_cnt_reg <= {18'd0, blank_reg};
        sum_reg        <= blank_reg ? 16'(weight) : 16'd0;
      end else if (blank_reg) begin
        if (active_cnt_reg != ACTIVE_MAX) begin
          active_cnt_reg <= active_cnt_reg + 19'd1;
        end
        sum_reg <= sum_reg + 16'(weight);
      end

      if (hfall) begin
        x_reg <= 10'd0;
      end else if (blank_reg) begin
        x_reg <= x_reg + 10'd1;
      end

      if (hfall) begin
        line_active_reg <= 1'b0;
      end else if (blank_reg) begin
        line_active_reg <= 1'b1;
      end

      // Blank lines (porches, sync) leave the row number alone.
      if (vfall) begin
        y_reg <= 10'd0;
      end else if (hfall && line_active_reg) begin
        y_reg <= y_reg + 10'd1;
      end
    end
  end

  assign line_bad  = hfall && (hcnt_reg != HCNT_GOOD);
  assign frame_bad = vfall && ((vcnt_reg != VCNT_GOOD) || (active_cnt_reg != ACTIVE_GOOD));
  assign check_err = (state_reg != HUNT) && (line_bad || frame_bad);
  assign lock_next = !check_err &&
                     ((state_reg == LOCKED) || ((state_reg == MEASURE) && vfall));

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_reg  <= HUNT;
      locked     <= 1'b0;
      frame_done <= 1'b0;
      timing_err <= 1'b0;
      frame_sum  <= 16'd0;
    end else begin
      frame_done <= 1'b0;
      timing_err <= 1'b0;
      locked     <= lock_next;
      case (state_reg)
        HUNT: begin
          if (vfall) begin
            state_reg <= MEASURE;
          end
        end
        MEASURE, LOCKED: begin
          if (check_err) begin
            state_reg  <= HUNT;
            timing_err <= 1'b1;
          end else if (vfall) begin
            state_reg  <= LOCKED;
            frame_done <= 1'b1;
            frame_sum  <= sum_reg;
          end
        end
        default: state_reg <= HUNT;
      endcase
    end
  end

  // Second pipeline stage: pixel data aligned with the lock decision for its sample.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pixel_valid <= 1'b0;
      pixelx      <= 10'd0;
      pixely      <= 10'd0;
      pix_r       <= 8'd0;
      pix_g       <= 8'd0;
      pix_b       <= 8'd0;
    end else begin
      pixel_valid <= lock_next && blank_reg;
      pixelx      <= x_reg;
      pixely      <= y_reg;
      pix_r       <= r_reg;
      pix_g       <= g_reg;
      pix_b       <= b_reg;
    end
  end

endmodule
